// File: rtl/temp_servo_startup_sequencer_if.sv
// Control/status bundle between top-level control, the servo startup ramps
// and temp_servo_startup_sequencer.
interface temp_servo_startup_sequencer_if #(
    parameter int NCH = 4,
    parameter int TW  = 32,
    parameter int CW  = 4
);
    logic           start;
    logic           stop;
    logic [NCH-1:0] pid_en;
    logic [TW-1:0]  timeout;
    logic [TW-1:0]  settle;
    logic [NCH-1:0] ch_on;
    logic [CW-1:0]  cur_ch;
    logic           busy;
    logic           done;
    logic [NCH-1:0] fault;

    modport master (
        output start, stop, pid_en, timeout, settle,
        input  ch_on, cur_ch, busy, done, fault
    );

    modport slave (
        input  start, stop, pid_en, timeout, settle,
        output ch_on, cur_ch, busy, done, fault
    );
endinterface

// File: rtl/temp_servo_startup_sequencer.sv
// Brings servo channels up one at a time: enable, wait for PID lock, settle, advance.
// Define STARTUP_SEQ_RETRY_EN to give each channel one 16-cycle off/retry before it faults.
module temp_servo_startup_sequencer #(
    parameter int NCH = 4,
    parameter int TW  = 32,
    parameter int CW  = 4
) (
    input logic clk,
    input logic rst_n,
    temp_servo_startup_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOCK,
        SETTLE,
        NEXT,
        DONE
`ifdef STARTUP_SEQ_RETRY_EN
        , RETRY_OFF
`endif
    } state_e;

    state_e         state;
    logic [TW-1:0]  cnt;
    logic [TW-1:0]  cnt_inc;
    logic [NCH-1:0] cur_mask;
    logic           locked;
    logic           last_ch;
    logic           tmo_hit;
    logic           settle_hit;
`ifdef STARTUP_SEQ_RETRY_EN
    logic           retried;
`endif

    always_comb begin
        // NOTE: assign a default before the loop so no path leaves the mask unassigned, which would infer a latch.
        cur_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            cur_mask[i] = (bus.cur_ch == CW'(i));
        end
    end

    // Counter saturates so an unbounded wait (timeout == 0) can never wrap.
    assign cnt_inc    = (&cnt) ? cnt : cnt + TW'(1);
    assign locked     = |(bus.pid_en & cur_mask);
    assign last_ch    = (bus.cur_ch == CW'(NCH - 1));
    assign tmo_hit    = (bus.timeout != '0) && (cnt == bus.timeout - TW'(1));
    assign settle_hit = (bus.settle == '0) || (cnt == bus.settle - TW'(1));

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bus.ch_on  <= '0;
            bus.cur_ch <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.fault  <= '0;
`ifdef STARTUP_SEQ_RETRY_EN
            retried    <= 1'b0;
`endif
        end else if (bus.stop) begin
            // Faults survive a stop so control can inspect them.
            state      <= IDLE;
            cnt        <= '0;
            bus.ch_on  <= '0;
            bus.cur_ch <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.fault  <= '0;
                        bus.cur_ch <= '0;
                        cnt        <= '0;
                        bus.ch_on  <= NCH'(1);
                        bus.busy   <= 1'b1;
`ifdef STARTUP_SEQ_RETRY_EN
                        retried    <= 1'b0;
`endif
                        state      <= WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    cnt <= cnt_inc;
                    if (locked) begin
                        cnt   <= '0;
                        state <= SETTLE;
                    end else if (tmo_hit) begin
                        bus.ch_on <= bus.ch_on & ~cur_mask;
                        cnt       <= '0;
`ifdef STARTUP_SEQ_RETRY_EN
                        if (!retried) begin
                            retried <= 1'b1;
                            state   <= RETRY_OFF;
                        end else begin
                            bus.fault <= bus.fault | cur_mask;
                            state     <= NEXT;
                        end
`else
                        bus.fault <= bus.fault | cur_mask;
                        state     <= NEXT;
`endif
                    end
                end
                SETTLE: begin
                    cnt <= cnt_inc;
                    if (!locked) begin
                        cnt   <= '0;
                        state <= WAIT_LOCK;
                    end else if (settle_hit) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (last_ch) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        bus.cur_ch <= bus.cur_ch + CW'(1);
                        bus.ch_on  <= bus.ch_on | (cur_mask << 1);
                        cnt        <= '0;
`ifdef STARTUP_SEQ_RETRY_EN
                        retried    <= 1'b0;
`endif
                        state      <= WAIT_LOCK;
                    end
                end
`ifdef STARTUP_SEQ_RETRY_EN
                RETRY_OFF: begin
                    // Ramp is held off for 16 cycles so it can reload its preset.
                    cnt <= cnt_inc;
                    if (cnt == TW'(15)) begin
                        bus.ch_on <= bus.ch_on | cur_mask;
                        cnt       <= '0;
                        state     <= WAIT_LOCK;
                    end
                end
`endif
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_servo_startup_sequencer.sv
// Randomised bench for temp_servo_startup_sequencer: expected outputs come from a
// per-channel event schedule (rise/fall/fault/done edges) computed arithmetically.
module tb_temp_servo_startup_sequencer;

    localparam int NCH = 4;
    localparam int TW  = 32;
    localparam int CW  = 4;
    localparam int BIG = 1 << 30;

    typedef enum int {K_LOCK, K_DROP, K_NEVER} kind_e;
    typedef enum int {AB_STOP, AB_RESET} abort_e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    temp_servo_startup_sequencer_if #(.NCH(NCH), .TW(TW), .CW(CW)) bus ();

    temp_servo_startup_sequencer #(.NCH(NCH), .TW(TW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Scenario description
    int    tmo, stl;
    kind_e knd [NCH];
    int    d1 [NCH], pw [NCH], d2 [NCH];

    // Derived schedule (absolute edge numbers)
    int rise [NCH], off [NCH], rise2 [NCH], off2 [NCH], flt [NCH], fin [NCH];
    int done_t, s_t, abort_t;
    abort_e ab_kind;
    logic [NCH-1:0] fault_idle = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Lock happens d edges after the wait begins; NEXT follows max(settle,1) edges later.
    task automatic plan(input int s);
        int r;
        int set_len;
        r       = s;
        set_len = (stl > 1) ? stl : 1;
        for (int c = 0; c < NCH; c++) begin
            rise[c] = r; off[c] = BIG; rise2[c] = BIG; off2[c] = BIG; flt[c] = BIG;
            case (knd[c])
                K_LOCK: fin[c] = r + d1[c] + set_len;
                K_DROP: fin[c] = r + d1[c] + pw[c] + d2[c] + set_len;
                default: begin
`ifdef STARTUP_SEQ_RETRY_EN
                    off[c]   = r + tmo;
                    rise2[c] = r + tmo + 16;
                    off2[c]  = r + 2 * tmo + 16;
                    flt[c]   = off2[c];
`else
                    off[c]   = r + tmo;
                    flt[c]   = off[c];
`endif
                    fin[c] = flt[c];
                end
            endcase
            r = fin[c] + 1;
        end
        done_t = r;
    endtask

    // Ramp model: value of pid_en[c] sampled at edge n. Outside the service window it is noise.
    function automatic logic pid_bit(input int c, input int n);
        int r;
        r = rise[c];
        if (n <= r || n > fin[c] || n > abort_t) return logic'($urandom_range(0, 1));
        case (knd[c])
            K_LOCK:  return n >= r + d1[c];
            K_DROP:  return (n >= r + d1[c] && n < r + d1[c] + pw[c]) ||
                            (n >= r + d1[c] + pw[c] + d2[c]);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [NCH-1:0] fault_at(input int n);
        logic [NCH-1:0] f;
        if (n < s_t) return fault_idle;
        f = '0;
        for (int c = 0; c < NCH; c++) f[c] = (n >= flt[c]);
        return f;
    endfunction

    task automatic check_cycle(input int n);
        logic [NCH-1:0] e_on, e_flt;
        int e_cur;
        logic e_busy, e_done;
        e_on = '0; e_cur = 0; e_busy = 1'b0; e_done = 1'b0;
        if (n >= abort_t) begin
            e_flt = (ab_kind == AB_RESET) ? '0 : fault_at(abort_t - 1);
        end else if (n < s_t) begin
            e_flt = fault_idle;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if ((n >= rise[c] && n < off[c]) || (n >= rise2[c] && n < off2[c])) e_on[c] = 1'b1;
                if (rise[c] <= n) e_cur = c;
            end
            e_busy = (n < done_t);
            e_done = (n >= done_t);
            e_flt  = fault_at(n);
        end
        check("ch_on",  32'(bus.ch_on),  32'(e_on));
        check("cur_ch", 32'(bus.cur_ch), 32'(e_cur));
        check("busy",   32'(bus.busy),   32'(e_busy));
        check("done",   32'(bus.done),   32'(e_done));
        check("fault",  32'(bus.fault),  32'(e_flt));
    endtask

    // ab_ch < 0: stop a few edges after DONE; otherwise abort ab_k edges after channel ab_ch rises.
    task automatic run_scenario(input bit do_reset, input int idle_len, input abort_e ab,
                                input int ab_ch, input int ab_k);
        logic [NCH-1:0] pv;
        bus.timeout = TW'(tmo);
        bus.settle  = TW'(stl);
        if (do_reset) begin
            rst_n     = 1'b0;
            bus.start = 1'($urandom_range(0, 1));
            bus.stop  = 1'b0;
            bus.pid_en = NCH'($urandom_range(0, (1 << NCH) - 1));
            tick();
            check("rst_ch_on",  32'(bus.ch_on),  32'd0);
            check("rst_cur_ch", 32'(bus.cur_ch), 32'd0);
            check("rst_busy",   32'(bus.busy),   32'd0);
            check("rst_done",   32'(bus.done),   32'd0);
            check("rst_fault",  32'(bus.fault),  32'd0);
            rst_n      = 1'b1;
            fault_idle = '0;
        end
        s_t     = cyc + idle_len + 1;
        abort_t = BIG;
        plan(s_t);
        ab_kind = ab;
        abort_t = (ab_ch < 0) ? done_t + 5 : rise[ab_ch] + ab_k;
        for (int n = cyc + 1; n <= abort_t + 3; n++) begin
            bus.start = (n == s_t) || (n == abort_t && ab == AB_STOP) ||
                        (n > s_t && n < abort_t && $urandom_range(0, 15) == 0);
            bus.stop  = (n == abort_t && ab == AB_STOP) ||
                        (n < s_t - 1 && $urandom_range(0, 3) == 0);
            rst_n     = !(n == abort_t && ab == AB_RESET);
            for (int c = 0; c < NCH; c++) pv[c] = pid_bit(c, n);
            bus.pid_en = pv;
            tick();
            check_cycle(n);
        end
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        rst_n      = 1'b1;
        fault_idle = (ab == AB_RESET) ? '0 : fault_at(abort_t - 1);
    endtask

    task automatic cfg(input int t, input int st, input int dd1);
        tmo = t;
        stl = st;
        for (int c = 0; c < NCH; c++) begin
            knd[c] = K_LOCK; d1[c] = dd1; pw[c] = 1; d2[c] = 1;
        end
    endtask

    task automatic rand_cfg();
        int r, lim;
        r   = $urandom_range(0, 5);
        tmo = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 2 : int'($urandom_range(3, 60));
        r   = $urandom_range(0, 4);
        stl = (r == 0) ? 0 : (r == 1) ? 1 : int'($urandom_range(2, 20));
        lim = (tmo == 0) ? 80 : tmo;
        for (int c = 0; c < NCH; c++) begin
            knd[c] = kind_e'($urandom_range(0, 2));
            if (knd[c] == K_NEVER && tmo == 0) knd[c] = K_LOCK;
            if (knd[c] == K_DROP && stl < 2)  knd[c] = K_LOCK;
            d1[c] = ($urandom_range(0, 3) == 0) ? lim : int'($urandom_range(1, lim));
            d2[c] = int'($urandom_range(1, lim));
            pw[c] = (stl >= 2) ? int'($urandom_range(1, stl - 1)) : 1;
        end
    endtask

    initial begin
        int r;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.pid_en  = '0;
        bus.timeout = '0;
        bus.settle  = '0;

        // Normal sequence: lock 50 cycles after enable, settle 10
        cfg(1000, 10, 50);
        run_scenario(1'b1, 3, AB_STOP, -1, 0);

        // Channel 1 never locks
        cfg(100, 10, 50);
        knd[1] = K_NEVER;
        run_scenario(1'b0, 2, AB_STOP, -1, 0);

        // Lock on channel 0 drops after 3 cycles of settling, then recovers
        cfg(1000, 10, 15);
        knd[0] = K_DROP; d1[0] = 20; pw[0] = 3; d2[0] = 30;
        run_scenario(1'b0, 2, AB_STOP, -1, 0);

        // Stop (with start) during channel 2 wait, fault on channel 1 retained
        cfg(100, 5, 10);
        knd[1] = K_NEVER;
        run_scenario(1'b0, 2, AB_STOP, 2, 5);

        // Next accepted start clears the retained fault
        cfg(50, 3, 10);
        run_scenario(1'b0, 4, AB_STOP, -1, 0);

        // Reset mid-sequence
        cfg(50, 3, 10);
        run_scenario(1'b0, 2, AB_RESET, 1, 7);

        // Boundary: wait forever, no settle, arbitrary lock delays
        cfg(0, 0, 1);
        for (int c = 0; c < NCH; c++) d1[c] = int'($urandom_range(1, 150));
        run_scenario(1'b1, 2, AB_STOP, -1, 0);

        // Lock exactly on the timeout edge
        cfg(7, 2, 7);
        run_scenario(1'b0, 1, AB_STOP, -1, 0);

        repeat (25) begin
            rand_cfg();
            r = $urandom_range(0, 9);
            if (r < 5)
                run_scenario(1'($urandom_range(0, 2) == 0), int'($urandom_range(1, 4)),
                             AB_STOP, -1, 0);
            else
                run_scenario(1'($urandom_range(0, 2) == 0), int'($urandom_range(1, 4)),
                             (r < 8) ? AB_STOP : AB_RESET,
                             int'($urandom_range(0, NCH - 1)), int'($urandom_range(1, 30)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/temp_servo_startup_sequencer.md
# temp_servo_startup_sequencer

Sequences the startup of several temperature servo channels so that only one startup ramp runs at a time. This limits peak heater current at power-on. It sits between top-level control and a bank of startup-ramp instances: it drives each ramp's `on` input and monitors each ramp's `PID_EN`. Channels are brought up in index order, 0 first. Each channel must reach PID enable, then hold through a settle interval, before the next channel is enabled.

## Interface
- `NCH`, default 4: number of servo channels, 1..16.
- `TW`, default 32: width of the timeout and settle counters.
- `CW`, default 4: width of `cur_ch`; must satisfy 2^CW ≥ NCH.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin the sequence; honoured only in IDLE.
- `stop`  in  1  when high, returns the block to IDLE on the next edge from any state.
- `pid_en`  in  NCH  PID_EN outputs from the ramps, synchronous to `clk`.
- `timeout`  in  TW  maximum cycles to wait for `pid_en`; 0 means wait forever.
- `settle`  in  TW  cycles to hold after lock before advancing; 0 means advance immediately.
- `ch_on`  out  NCH  `on` drives to the ramps.
- `cur_ch`  out  CW  index of the channel being serviced.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `fault`  out  NCH  sticky per-channel timeout flags.

## Operation
- Reset value of every output is 0: `ch_on`, `cur_ch`, `busy`, `done`, `fault`. The state and counter also reset to 0 and IDLE.
- **IDLE:**
  - `start` clears `fault` and `cur_ch`, clears the counter, and moves to WAIT_LOCK.
  - `ch_on[0]` is set on the same edge.
- **WAIT_LOCK:**
  - The counter increments every cycle.
  - If `pid_en[cur_ch]` is high, clear the counter and go to SETTLE. Lock takes priority over timeout in the same cycle.
  - Else, if `timeout` ≠ 0 and counter == `timeout`−1, the channel has timed out: set `fault[cur_ch]`, clear `ch_on[cur_ch]`, and go to NEXT. With `STARTUP_SEQ_RETRY_EN`, see Configuration.
- **SETTLE:**
  - The counter increments every cycle.
  - When counter == `settle`−1, or immediately if `settle` == 0, go to NEXT.
  - If `pid_en[cur_ch]` falls during SETTLE, clear the counter and go back to WAIT_LOCK. The timeout restarts.
- **NEXT:**
  - If `cur_ch` == NCH−1, go to DONE.
  - Otherwise increment `cur_ch`, set the new `ch_on` bit, clear the counter, and go to WAIT_LOCK.
- **DONE:** holds `ch_on` and `fault`. `start` is ignored; only `stop` or reset leaves DONE.
- **`stop`:**
  - Overrides every other input, including a simultaneous `start`.
  - On the next edge: state = IDLE, `ch_on` = 0, counter = 0, `cur_ch` = 0.
  - `fault` is retained until the next accepted `start`.
- **`start` outside IDLE:** ignored.
- **Lock bits:** channels already locked keep `ch_on` set. Their `pid_en` bits are not monitored after they leave SETTLE.
- **Counter saturation:** counter width is TW and saturates at all-ones. With `timeout` = 0, WAIT_LOCK waits indefinitely and never wraps.
- **Reset mid-sequence:** all ramps are turned off on the reset edge.

## Timing
- `start` sampled at edge k → `ch_on[0]` and `busy` high after edge k.
- `pid_en[c]` high at edge j → SETTLE after edge j.
- With `settle` = S > 0, NEXT is entered S edges after SETTLE entry. The next channel's `ch_on` is set one edge later.
- Per-channel overhead with `settle` = 0 is 2 cycles: lock → NEXT → next `ch_on`.
- Timeout with `timeout` = T: `fault` and `ch_on` clear exactly T edges after WAIT_LOCK entry.
- `done` rises one edge after NEXT for the last channel. `busy` falls on the same edge.

## Configuration
- **`STARTUP_SEQ_RETRY_EN` defined:**
  - On the first timeout of a channel, clear its `ch_on` for exactly 16 cycles in a RETRY_OFF state. This lets the ramp reset its preset.
  - Then set `ch_on` again and re-enter WAIT_LOCK with the counter cleared.
  - A second timeout on the same channel sets `fault` and goes to NEXT.
  - `fault` is not set by a first timeout.
- **Not defined:** no RETRY_OFF state. The first timeout faults the channel and skips it.

## Test plan
- **Normal sequence.** NCH=4, `timeout`=1000, `settle`=10, `pid_en[c]` driven high 50 cycles after `ch_on[c]` rises → `ch_on` goes 0001, 0011, 0111, 1111. Spacing between rises is 50+10+1 cycles. `done` is high, `fault`=0.
- **Timeout without retry.** `pid_en[1]` never rises, `timeout`=100 → `ch_on[1]` clears 100 cycles after it rose. `fault`=0010, channels 2 and 3 still start, `done`=1.
- **Timeout with retry.** Same stimulus with `STARTUP_SEQ_RETRY_EN` defined → `ch_on[1]` is low for 16 cycles and then high again. `fault[1]` sets only after the second 100-cycle wait.
- **Lock drops during settle.** `pid_en[0]` pulses high for 3 cycles with `settle`=10 → state returns to WAIT_LOCK and `ch_on[1]` is not asserted. A later stable lock advances the sequence.
- **Stop mid-sequence.** `stop` asserted during WAIT_LOCK of channel 2, with `start` high in the same cycle → `ch_on`=0 and `busy`=0 after one edge. `fault` is preserved; a later `start` clears it.
- **Reset and boundary values.** `rst_n` low mid-sequence → all outputs are 0 after one edge. With `timeout`=0 and `settle`=0, each channel locks after an arbitrary delay, the sequence advances 2 cycles after each lock, and no fault is set.
